// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: quadrature encoder emulator.
// Emits A/B quadrature at a commanded edge rate, direction and edge count,
// and keeps a signed 16-bit position count.
// Optional feature macro: QENC_INDEX_EN adds a revolution counter that drives
// a Z index pulse. Without it, index_out is tied low.
module quad_encoder_gen #(
  parameter int PERIOD_W      = 24,
  parameter int COUNT_W       = 16,
  parameter int EDGES_PER_REV = 400
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                cmd_dir,
  input  logic [COUNT_W-1:0]  cmd_count,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [1:0]          enc_out,
  output logic [15:0]         position,
  output logic                index_out
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PERIOD_W-1:0] timer_q;
  logic [COUNT_W-1:0]  remain_q;
  logic                cont_q;
  logic                dir_q;
  logic                busy_q;
  logic                done_q;
  logic [1:0]          enc_q;
  logic [15:0]         pos_q;

  logic                step_s;
  logic                final_s;
  logic                take_step_s;
  logic [1:0]          enc_d;
  logic [15:0]         pos_d;

  // Next {B,A} code one quadrature step away from cur; dir = 1 walks
  // 00->01->11->10->00, dir = 0 walks the same ring backward.
  function automatic logic [1:0] next_enc(input logic [1:0] cur, input logic dir);
    logic [1:0] nxt;
    case (cur)
      2'b00:   nxt = dir ? 2'b01 : 2'b10;
      2'b01:   nxt = dir ? 2'b11 : 2'b00;
      2'b11:   nxt = dir ? 2'b10 : 2'b01;
      2'b10:   nxt = dir ? 2'b00 : 2'b11;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = busy_q;
  assign done      = done_q;
  assign enc_out   = enc_q;
  assign position  = pos_q;

  // Step strobe, completion detect and next encoder/position values.
  // A final step wins over abort; any other step is suppressed by abort.
  always_comb begin
    step_s      = 1'b0;
    final_s     = 1'b0;
    take_step_s = 1'b0;
    enc_d       = next_enc(enc_q, dir_q);
    pos_d       = dir_q ? (pos_q + 16'd1) : (pos_q - 16'd1);
    if (state_q == ST_RUN) begin
      step_s      = (timer_q == (period_q - PERIOD_W'(1)));
      final_s     = step_s && !cont_q && (remain_q == COUNT_W'(1));
      take_step_s = final_s || (step_s && !abort);
    end else begin
      step_s      = 1'b0;
      final_s     = 1'b0;
      take_step_s = 1'b0;
    end
  end

  // Command FSM: latch in IDLE, pace steps in RUN, finish or abort back to IDLE.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= ST_IDLE;
      period_q <= PERIOD_W'(1);
      timer_q  <= '0;
      remain_q <= '0;
      cont_q   <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      enc_q    <= 2'b00;
      pos_q    <= 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (cmd_valid) begin
            period_q <= (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
            dir_q    <= cmd_dir;
            remain_q <= cmd_count;
            cont_q   <= (cmd_count == '0);
            timer_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (final_s) begin
            enc_q    <= enc_d;
            pos_q    <= pos_d;
            remain_q <= '0;
            timer_q  <= '0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (abort) begin
            timer_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (take_step_s) begin
            enc_q   <= enc_d;
            pos_q   <= pos_d;
            timer_q <= '0;
            done_q  <= 1'b0;
            if (!cont_q) begin
              remain_q <= remain_q - COUNT_W'(1);
            end else begin
              remain_q <= remain_q;
            end
          end else begin
            timer_q <= timer_q + PERIOD_W'(1);
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef QENC_INDEX_EN
  localparam int REV_W = (EDGES_PER_REV > 1) ? $clog2(EDGES_PER_REV) : 1;
  localparam logic [REV_W-1:0] REV_MAX = REV_W'(EDGES_PER_REV - 1);

  logic [REV_W-1:0] rev_q;
  logic [REV_W-1:0] rev_d;
  logic             index_q;

  // Revolution position one step ahead, wrapping at both ends.
  always_comb begin
    rev_d = rev_q;
    if (dir_q) begin
      rev_d = (rev_q == REV_MAX) ? '0 : (rev_q + REV_W'(1));
    end else begin
      rev_d = (rev_q == '0) ? REV_MAX : (rev_q - REV_W'(1));
    end
  end

  // Revolution counter and registered index pulse, updated on emitted steps.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rev_q   <= '0;
      index_q <= 1'b0;
    end else if (take_step_s) begin
      rev_q   <= rev_d;
      index_q <= (rev_d == '0);
    end else begin
      rev_q   <= rev_q;
      index_q <= index_q;
    end
  end

  assign index_out = index_q;
`else
  // No revolution tracking in this build; the index line stays low for any
  // EDGES_PER_REV.
  assign index_out = (EDGES_PER_REV > 0) ? 1'b0 : 1'b0;
`endif

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Directed self-checking bench for quad_encoder_gen.
// Build with QENC_INDEX_EN defined to add the index-pulse section.
module tb_quad_encoder_gen;

`ifdef QENC_INDEX_EN
  localparam int EPR = 8;
`else
  localparam int EPR = 400;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_period;
  logic        cmd_dir;
  logic [15:0] cmd_count;
  logic        abort;
  logic        busy;
  logic        done;
  logic [1:0]  enc_out;
  logic [15:0] position;
  logic        index_out;

  int total = 0;
  int bad   = 0;

  quad_encoder_gen #(
    .PERIOD_W(24), .COUNT_W(16), .EDGES_PER_REV(EPR)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_period(cmd_period), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
    .abort(abort), .busy(busy), .done(done),
    .enc_out(enc_out), .position(position), .index_out(index_out)
  );

  always #5 clk_clk = ~clk_clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [23:0] p, input logic d, input logic [15:0] c);
    cmd_period = p;
    cmd_dir    = d;
    cmd_count  = c;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
  endtask

  logic [1:0] fwd_seq [8] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] rev_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] back_seq[3] = '{2'b11, 2'b01, 2'b00};
  int         busy_cycles;

  initial begin
    reset_reset = 1'b1;
    cmd_valid   = 1'b0;
    cmd_period  = 24'd0;
    cmd_dir     = 1'b0;
    cmd_count   = 16'd0;
    abort       = 1'b0;
    tick();
    tick();
    reset_reset = 1'b0;

    // Reset state
    check("rst_enc",   16'(enc_out),   16'h0000);
    check("rst_pos",   position,       16'h0000);
    check("rst_busy",  16'(busy),      16'h0000);
    check("rst_done",  16'(done),      16'h0000);
    check("rst_ready", 16'(cmd_ready), 16'h0001);
    check("rst_index", 16'(index_out), 16'h0000);

    // Forward, period 5, count 8
    start(24'd5, 1'b1, 16'd8);
    check("t1_busy", 16'(busy), 16'h0001);
    check("t1_ready", 16'(cmd_ready), 16'h0000);
    for (int i = 0; i < 8; i++) begin
      for (int h = 0; h < 4; h++) begin
        tick();
        check("t1_hold", 16'(enc_out), (i == 0) ? 16'h0000 : 16'(fwd_seq[(i == 0) ? 0 : i - 1]));
      end
      tick();
      check("t1_step", 16'(enc_out), 16'(fwd_seq[i]));
      check("t1_done", 16'(done), (i == 7) ? 16'h0001 : 16'h0000);
    end
    check("t1_pos",   position,       16'd8);
    check("t1_busy0", 16'(busy),      16'h0000);
    check("t1_rdy1",  16'(cmd_ready), 16'h0001);
    tick();
    check("t1_done_pulse", 16'(done), 16'h0000);

    // Reverse, period 1, count 4, from a fresh position
    do_reset();
    start(24'd1, 1'b0, 16'd4);
    busy_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy) busy_cycles++;
      tick();
      check("t2_step", 16'(enc_out), 16'(rev_seq[i]));
    end
    check("t2_busy_cycles", 16'(busy_cycles), 16'd4);
    check("t2_busy0", 16'(busy), 16'h0000);
    check("t2_done",  16'(done), 16'h0001);
    check("t2_pos",   position,  16'hfffc);

    // Continuous forward, period 3, abort after 7 transitions
    do_reset();
    start(24'd3, 1'b1, 16'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      tick();
      tick();
      check("t3_step", 16'(enc_out), 16'(fwd_seq[i]));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t3_enc",   16'(enc_out),   16'h0002);
    check("t3_pos",   position,       16'd7);
    check("t3_done",  16'(done),      16'h0000);
    check("t3_busy",  16'(busy),      16'h0000);
    check("t3_ready", 16'(cmd_ready), 16'h0001);
    tick();
    tick();
    check("t3_held", 16'(enc_out), 16'h0002);
    check("t3_nodone", 16'(done), 16'h0000);
    // Reverse from the held 10 state, period 2, count 3
    start(24'd2, 1'b0, 16'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_rhold", 16'(enc_out), (i == 0) ? 16'h0002 : 16'(back_seq[(i == 0) ? 0 : i - 1]));
      tick();
      check("t3_rstep", 16'(enc_out), 16'(back_seq[i]));
    end
    check("t3_rpos",  position,  16'd4);
    check("t3_rdone", 16'(done), 16'h0001);

    // Period 0 with count 2; cmd_valid kept high while busy with another command
    tick();
    start(24'd0, 1'b1, 16'd2);
    cmd_period = 24'd7;
    cmd_dir    = 1'b0;
    cmd_count  = 16'd9;
    cmd_valid  = 1'b1;
    tick();
    check("t4_s1", 16'(enc_out), 16'h0001);
    check("t4_busy", 16'(busy), 16'h0001);
    tick();
    cmd_valid = 1'b0;
    check("t4_s2",   16'(enc_out), 16'h0003);
    check("t4_done", 16'(done),    16'h0001);
    check("t4_pos",  position,     16'd6);
    tick();
    tick();
    check("t4_no2nd_busy", 16'(busy),    16'h0000);
    check("t4_no2nd_enc",  16'(enc_out), 16'h0003);

    // Reset pulsed mid-run
    do_reset();
    start(24'd2, 1'b1, 16'd10);
    repeat (5) tick();
    check("t5_running", 16'(enc_out), 16'h0003);
    do_reset();
    check("t5_enc",   16'(enc_out),   16'h0000);
    check("t5_pos",   position,       16'h0000);
    check("t5_busy",  16'(busy),      16'h0000);
    check("t5_ready", 16'(cmd_ready), 16'h0001);
    repeat (4) tick();
    check("t5_dropped", 16'(enc_out), 16'h0000);

    // Abort coincident with the final step
    start(24'd2, 1'b1, 16'd2);
    tick();
    tick();
    check("t6_s1", 16'(enc_out), 16'h0001);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_s2",   16'(enc_out), 16'h0003);
    check("t6_done", 16'(done),    16'h0001);
    check("t6_pos",  position,     16'd2);
    check("t6_busy", 16'(busy),    16'h0000);

`ifdef QENC_INDEX_EN
    // Index pulse: 20 forward edges with 8 edges per revolution
    do_reset();
    start(24'd1, 1'b1, 16'd20);
    for (int i = 1; i <= 20; i++) begin
      tick();
      check("t7_index", 16'(index_out), (i == 8 || i == 16) ? 16'h0001 : 16'h0000);
    end
`else
    check("t7_index_tied", 16'(index_out), 16'h0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
